// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with a two-requester ratio-change arbiter.
// Ratio changes are deferred to a period boundary so clk_out never glitches.
module clk_div_ctrl #(
  parameter int unsigned DIV_W   = 4,
  parameter int unsigned DEF_DIV = 5
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             req_a,
  input  logic [DIV_W-1:0] div_a,
  input  logic             req_b,
  input  logic [DIV_W-1:0] div_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             err_a,
  output logic             err_b,
  output logic             busy,
  output logic [DIV_W-1:0] div_cur,
  output logic             clk_out,
  output logic             clk_flag
);

  localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    PEND
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] div_nxt;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] win_div;
  logic             run;
  logic             last_b;
  logic             win_b;
  logic             legal;
  logic             arb;
  logic             boundary;
  logic             apply;
  logic             gnt_a_nxt, gnt_b_nxt, err_a_nxt, err_b_nxt, busy_nxt;
  logic             clk_pos, clk_pos_nxt, clk_neg, clk_flag_nxt;

  // last_b=1 means B was served last, so A wins a tie.
  always_comb begin
    win_b    = req_b & ~(req_a & last_b);
    win_div  = win_b ? div_b : div_a;
    legal    = (win_div >= DIV_MIN);
    boundary = run & (cnt == (div_cur - DIV_ONE));

    state_nxt = state;
    arb       = 1'b0;
    apply     = 1'b0;
    gnt_a_nxt = 1'b0;
    gnt_b_nxt = 1'b0;
    err_a_nxt = 1'b0;
    err_b_nxt = 1'b0;
    busy_nxt  = busy;

    case (state)
      IDLE: begin
        if (req_a | req_b) begin
          arb = 1'b1;
          if (legal) begin
            state_nxt = GRANT;
            busy_nxt  = 1'b1;
            gnt_a_nxt = ~win_b;
            gnt_b_nxt = win_b;
          end else begin
            err_a_nxt = ~win_b;
            err_b_nxt = win_b;
          end
        end
      end
      GRANT, PEND: begin
        if (boundary) begin
          apply     = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          state_nxt = PEND;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // The first edge after reset starts period 0 instead of advancing the count.
    div_eff      = apply ? div_nxt : div_cur;
    cnt_nxt      = (!run || boundary) ? '0 : cnt + DIV_ONE;
    clk_pos_nxt  = (cnt_nxt < (div_eff >> 1));
    clk_flag_nxt = (cnt_nxt == (div_eff - DIV_ONE));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      run      <= 1'b0;
      div_cur  <= DEF_DIV_V;
      div_nxt  <= '0;
      last_b   <= 1'b1;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      err_a    <= 1'b0;
      err_b    <= 1'b0;
      busy     <= 1'b0;
      clk_pos  <= 1'b0;
      clk_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      run      <= 1'b1;
      gnt_a    <= gnt_a_nxt;
      gnt_b    <= gnt_b_nxt;
      err_a    <= err_a_nxt;
      err_b    <= err_b_nxt;
      busy     <= busy_nxt;
      clk_pos  <= clk_pos_nxt;
      clk_flag <= clk_flag_nxt;
      if (arb) begin
        last_b <= win_b;
      end
      if (arb && legal) begin
        div_nxt <= win_div;
      end
      if (apply) begin
        div_cur <= div_nxt;
      end
    end
  end

  always_ff @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      clk_neg <= 1'b0;
    end else begin
      clk_neg <= clk_pos;
    end
  end

  // div_cur only changes while clk_pos and clk_neg are both low, so the odd/even select is safe.
  assign clk_out = clk_pos | (div_cur[0] & clk_neg);

endmodule
